// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, requester id
// and the fixed access size used for instruction fetch.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        SRC_IF   = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam logic [2:0] FETCH_SIZE = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM
// stage; one transaction at a time, data first, with a fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              if_req,
    input  logic [WIDTH-1:0]                  if_addr,
    output logic [WIDTH-1:0]                  if_rdata,
    output logic                              if_valid,
    input  logic                              d_read,
    input  logic                              d_write,
    input  logic [WIDTH-1:0]                  d_addr,
    input  logic [WIDTH-1:0]                  d_wdata,
    input  logic [2:0]                        d_funct3,
    output logic [WIDTH-1:0]                  d_rdata,
    output logic                              d_done,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [WIDTH-1:0]                  mem_addr,
    output logic [WIDTH-1:0]                  mem_wdata,
    output logic [2:0]                        mem_size,
    input  logic                              mem_ready,
    input  logic                              mem_rvalid,
    input  logic [WIDTH-1:0]                  mem_rdata,
    output logic                              stall_if,
    output logic                              stall_mem,
    output logic [1:0]                        dbg_state,
    output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_streak
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    state_e           state_q;
    src_e             src_q;
    logic [SW-1:0]    streak_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic [2:0]       mem_size_q;
    logic [WIDTH-1:0] if_rdata_q;
    logic [WIDTH-1:0] d_rdata_q;
    logic             if_valid_q;
    logic             d_done_q;

    logic d_any;
    logic grant_if;
    logic grant_d;

    assign d_any = d_read | d_write;

    // A requester whose done pulse is high this cycle advances at this edge,
    // so its request is stale and must not be granted again.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE && !if_valid_q && !d_done_q) begin
            if (if_req && (streak_q == STREAK_MAX || !d_any)) begin
                grant_if = 1'b1;
            end else if (d_any) begin
                grant_d = 1'b1;
            end
        end
    end

    // Memory handshake: mem_req holds with stable operands until the cycle
    // mem_ready is seen; the response is the first mem_rvalid after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        state_q     <= REQ;
                        src_q       <= SRC_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_size_q  <= FETCH_SIZE;
                        streak_q    <= '0;
                    end else if (grant_d) begin
                        state_q     <= REQ;
                        src_q       <= SRC_DATA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_write;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_size_q  <= d_funct3;
                        if (if_req && streak_q != STREAK_MAX) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                        if (src_q == SRC_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                            d_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_size   = mem_size_q;
    assign if_rdata   = if_rdata_q;
    assign if_valid   = if_valid_q;
    assign d_rdata    = d_rdata_q;
    assign d_done     = d_done_q;
    assign stall_if   = if_req & ~if_valid_q;
    assign stall_mem  = d_any & ~d_done_q;
    assign dbg_state  = state_q;
    assign dbg_streak = streak_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory checked against a transaction model.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int SM = 4;
  localparam int SW = $clog2(SM + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [W-1:0]  if_addr = '0;
  logic [W-1:0]  if_rdata;
  logic          if_valid;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [W-1:0]  d_addr = '0;
  logic [W-1:0]  d_wdata = '0;
  logic [2:0]    d_funct3 = '0;
  logic [W-1:0]  d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [2:0]    mem_size;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [W-1:0]  mem_rdata = '0;
  logic          stall_if;
  logic          stall_mem;
  logic [1:0]    dbg_state;
  logic [SW-1:0] dbg_streak;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.WIDTH(W), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 = free, 1 = request offered, 2 = awaiting response
  int          m_phase;
  bit          m_is_fetch;
  bit          m_req;
  bit          m_we;
  logic [W-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic [2:0]  m_size;
  logic [W-1:0] m_ifr;
  logic [W-1:0] m_dr;
  bit          m_ifv;
  bit          m_dd;
  int          m_streak;

  task automatic model_reset();
    m_phase = 0; m_is_fetch = 1'b0; m_req = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_size = '0; m_ifr = '0; m_dr = '0;
    m_ifv = 1'b0; m_dd = 1'b0; m_streak = 0;
  endtask

  task automatic model_next();
    bit nifv;
    bit ndd;
    bit dreq;
    if (rst) begin
      model_reset();
      return;
    end
    nifv = 1'b0;
    ndd  = 1'b0;
    dreq = d_read | d_write;
    if (m_phase == 0) begin
      if (!m_ifv && !m_dd) begin
        if (if_req && (m_streak == SM || !dreq)) begin
          m_is_fetch = 1'b1; m_req = 1'b1; m_phase = 1;
          m_addr = if_addr; m_we = 1'b0; m_wdata = '0; m_size = 3'b010;
          m_streak = 0;
        end else if (dreq) begin
          m_is_fetch = 1'b0; m_req = 1'b1; m_phase = 1;
          m_addr = d_addr; m_we = d_write; m_wdata = d_wdata; m_size = d_funct3;
          if (if_req && m_streak < SM) m_streak = m_streak + 1;
        end
      end
    end else if (m_phase == 1) begin
      if (mem_ready) begin
        m_req = 1'b0;
        m_phase = 2;
      end
    end else begin
      if (mem_rvalid) begin
        m_phase = 0;
        if (m_is_fetch) begin
          m_ifr = mem_rdata;
          nifv = 1'b1;
        end else begin
          if (!m_we) m_dr = mem_rdata;
          ndd = 1'b1;
        end
      end
    end
    m_ifv = nifv;
    m_dd  = ndd;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("mem_req", W'(mem_req), W'(m_req));
    if (m_req) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", W'(mem_we), W'(m_we));
      chk("mem_size", W'(mem_size), W'(m_size));
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_valid", W'(if_valid), W'(m_ifv));
    chk("d_done", W'(d_done), W'(m_dd));
    chk("if_rdata", if_rdata, m_ifr);
    chk("d_rdata", d_rdata, m_dr);
    chk("stall_if", W'(stall_if), W'(if_req & ~m_ifv));
    chk("stall_mem", W'(stall_mem), W'((d_read | d_write) & ~m_dd));
    chk("state", W'(dbg_state), W'(m_phase));
    chk("streak", W'(dbg_streak), W'(m_streak));
  endtask

  // one clock: model advances with the inputs as they stand, outputs are
  // compared 1 time unit after the edge
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    compare();
  endtask

  // wait for mem_req, hold off mem_ready, then accept and respond
  task automatic serve(input int rdy_wait, input logic [W-1:0] rdata);
    int t;
    t = 0;
    while (!mem_req && t < 20) begin
      step();
      t++;
    end
    chk("serve_mem_req_seen", W'(mem_req), 32'd1);
    repeat (rdy_wait) step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int data_grants;
    int fetch_seen;
    int t;
    int resp_cnt;
    logic [W-1:0] hold_addr;

    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", W'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_size", W'(mem_size), 32'd0);
    chk("rst_if_valid", W'(if_valid), 32'd0);
    chk("rst_d_done", W'(d_done), 32'd0);
    chk("rst_state", W'(dbg_state), 32'd0);
    rst = 1'b0;
    step();

    // single fetch
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("sf_stall_if_c0", W'(stall_if), 32'd1);
    step();
    chk("sf_c1_mem_req", W'(mem_req), 32'd1);
    chk("sf_c1_mem_addr", mem_addr, 32'h100);
    chk("sf_c1_mem_size", W'(mem_size), 32'd2);
    chk("sf_c1_mem_we", W'(mem_we), 32'd0);
    chk("sf_c1_stall_if", W'(stall_if), 32'd1);
    mem_ready = 1'b1;
    step();
    chk("sf_c2_stall_if", W'(stall_if), 32'd1);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13;
    step();
    mem_rvalid = 1'b0;
    chk("sf_c3_if_valid", W'(if_valid), 32'd1);
    chk("sf_c3_if_rdata", if_rdata, 32'h13);
    chk("sf_c3_state_idle", W'(dbg_state), 32'd0);
    if_req = 1'b0;
    step();
    chk("sf_c4_if_valid_low", W'(if_valid), 32'd0);

    // simultaneous fetch and load: data first
    if_req = 1'b1; if_addr = 32'h104;
    d_read = 1'b1; d_addr = 32'h2000; d_funct3 = 3'b010;
    step();
    chk("sim_data_first", mem_addr, 32'h2000);
    serve(0, 32'hCAFE0001);
    chk("sim_d_done", W'(d_done), 32'd1);
    chk("sim_d_rdata", d_rdata, 32'hCAFE0001);
    d_read = 1'b0;
    step();
    chk("sim_no_grant_on_pulse", W'(mem_req), 32'd0);
    step();
    chk("sim_fetch_req", W'(mem_req), 32'd1);
    chk("sim_fetch_addr", mem_addr, 32'h104);
    serve(0, 32'h00000093);
    chk("sim_if_valid", W'(if_valid), 32'd1);
    if_req = 1'b0;
    step();

    // store
    d_write = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b000;
    step();
    chk("st_mem_we", W'(mem_we), 32'd1);
    chk("st_mem_size", W'(mem_size), 32'd0);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_mem_addr", mem_addr, 32'h3000);
    serve(0, 32'h12345678);
    chk("st_d_done", W'(d_done), 32'd1);
    chk("st_d_rdata_kept", d_rdata, 32'hCAFE0001);
    d_write = 1'b0;
    step();

    // backpressure: five cycles without mem_ready
    d_read = 1'b1; d_addr = 32'h4000; d_funct3 = 3'b100;
    step();
    hold_addr = mem_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_mem_req", W'(mem_req), 32'd1);
      chk("bp_mem_addr", mem_addr, 32'h4000);
      chk("bp_mem_size", W'(mem_size), 32'd4);
      chk("bp_stall_mem", W'(stall_mem), 32'd1);
    end
    chk("bp_addr_first", hold_addr, 32'h4000);
    serve(0, 32'h0BADF00D);
    chk("bp_d_done", W'(d_done), 32'd1);
    chk("bp_stall_mem_released", W'(stall_mem), 32'd0);
    d_read = 1'b0;
    step();

    // starvation: fetch held, loads keep coming
    if_req = 1'b1; if_addr = 32'h200;
    d_read = 1'b1; d_addr = 32'h5000; d_funct3 = 3'b010;
    data_grants = 0;
    fetch_seen = 0;
    for (int k = 0; k < 10 && fetch_seen == 0; k++) begin
      t = 0;
      while (!mem_req && t < 20) begin
        step();
        t++;
      end
      if (mem_req && mem_addr == 32'h200) begin
        fetch_seen = 1;
        chk("starve_streak_at_fetch", W'(dbg_streak), 32'd0);
        serve(0, 32'h00100073);
        chk("starve_if_valid", W'(if_valid), 32'd1);
        if_req = 1'b0;
        d_read = 1'b0;
      end else begin
        data_grants++;
        serve(0, 32'h5000 + 32'(k));
        d_addr = d_addr + 32'd4;
      end
    end
    chk("starve_fetch_seen", 32'(fetch_seen), 32'd1);
    chk("starve_data_grants", 32'(data_grants), 32'd4);
    step();

    // reset while waiting for the response
    d_read = 1'b1; d_addr = 32'h6000; d_funct3 = 3'b010;
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("rw_in_wait", W'(dbg_state), 32'd2);
    rst = 1'b1;
    d_read = 1'b0;
    #1;
    chk("rw_mem_req", W'(mem_req), 32'd0);
    chk("rw_mem_addr", mem_addr, 32'd0);
    chk("rw_mem_size", W'(mem_size), 32'd0);
    chk("rw_if_rdata", if_rdata, 32'd0);
    chk("rw_d_rdata", d_rdata, 32'd0);
    chk("rw_state", W'(dbg_state), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    step();
    rst = 1'b0;
    step();
    chk("rw_no_done", W'(d_done), 32'd0);
    mem_rvalid = 1'b0;
    step();
    chk("rw_no_done_late", W'(d_done), 32'd0);

    // randomized traffic
    resp_cnt = -1;
    for (int c = 0; c < 3000; c++) begin
      if (if_req && m_ifv) if_req = 1'b0;
      if (!if_req && $urandom_range(0, 99) < 30) begin
        if_req = 1'b1;
        if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if ((d_read || d_write) && m_dd) begin
        d_read = 1'b0;
        d_write = 1'b0;
      end
      if (!d_read && !d_write && $urandom_range(0, 99) < 35) begin
        case ($urandom_range(0, 2))
          0: d_read = 1'b1;
          1: d_write = 1'b1;
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_addr = $urandom();
        d_wdata = $urandom();
        d_funct3 = 3'($urandom_range(0, 7));
      end
      if (resp_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = $urandom();
        resp_cnt = -1;
      end else if (resp_cnt > 0) begin
        mem_rvalid = 1'b0;
        resp_cnt--;
      end else begin
        mem_rvalid = ($urandom_range(0, 99) < 15);
        mem_rdata = $urandom();
      end
      if (m_req) mem_ready = ($urandom_range(0, 99) < 50);
      else mem_ready = ($urandom_range(0, 99) < 15);
      if (m_req && mem_ready) resp_cnt = $urandom_range(0, 3);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between instruction fetch (IF) and the MEM stage of the pipelined RISC-V core. The MEM-stage request comes from the EX/MEM pipeline register outputs: memRead, memWrite, alu_result as address, write_data, and funct3. The block runs one transaction at a time through a variable-latency req/ready/rvalid memory handshake. It returns data to the requester and raises stall signals that the pipeline control uses to freeze stages. Data has priority over fetch, and a starvation counter guarantees fetch progress.

## Interface
- WIDTH, 32, address/data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  WIDTH  fetch address
- if_rdata  out  WIDTH  fetched instruction
- if_valid  out  1  one-cycle fetch-complete pulse
- d_read  in  1  load request (EX/MEM memRead)
- d_write  in  1  store request (EX/MEM memWrite)
- d_addr  in  WIDTH  data address
- d_wdata  in  WIDTH  store data
- d_funct3  in  3  access width/sign, forwarded as mem_size
- d_rdata  out  WIDTH  load data
- d_done  out  1  one-cycle data-complete pulse (loads and stores)
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_size  out  3  funct3 for data; 3'b010 for fetch
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  response/write-ack valid
- mem_rdata  in  WIDTH  response data
- stall_if  out  1  if_req & ~if_valid (combinational)
- stall_mem  out  1  (d_read | d_write) & ~d_done (combinational)

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE:**
  - No grant when if_valid or d_done is high this cycle. That request is stale because its stage advances at this edge.
  - Otherwise select a requester:
    - Fetch wins if if_req and streak == STARVE_MAX.
    - Otherwise data wins if d_read | d_write.
    - Otherwise fetch wins if if_req.
  - On a grant, register addr, wdata, we and size plus a src flag, then go to REQ.
- **REQ:** mem_req = 1. addr, we, wdata and size are held stable until mem_ready. On mem_ready, go to WAIT.
- **WAIT:** mem_req = 0. On mem_rvalid:
  - Fetch: load if_rdata, pulse if_valid.
  - Data load: load d_rdata, pulse d_done.
  - Store: pulse d_done only.
  - Then go to IDLE.
- If d_read and d_write are both high, treat as a store (mem_we = 1).
- **Streak counter** (width $clog2(STARVE_MAX+1)):
  - Increments, saturating at STARVE_MAX, on a data grant while if_req = 1.
  - Clears on any fetch grant.
  - Unchanged otherwise.
- mem_rvalid outside WAIT and mem_ready outside REQ are ignored.
- if_rdata and d_rdata hold their last loaded value. d_rdata is not written by stores.
- Requesters must keep request and operands stable until their done pulse. The block does not sample them after the grant.

## Timing
- **Reset values:**
  - state = IDLE, streak = 0.
  - mem_req, mem_we, if_valid, d_done = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0; mem_size = 0.
  - Reset mid-transaction aborts immediately. A late mem_rvalid is ignored and no done pulse is produced.
- **Grant timing:**
  - Cycle 0: request seen in IDLE.
  - Cycle 1: mem_req high (REQ).
  - If mem_ready is in cycle 1 and mem_rvalid is in cycle 2, the done pulse is in cycle 3. State is IDLE in cycle 3, with no grant that cycle.
- Minimum back-to-back period is 4 cycles per transaction.
- mem_req, mem_addr, mem_we, mem_wdata and mem_size are registered outputs. if_valid and d_done are registered pulses, exactly 1 cycle wide.
- mem_ready is allowed in the same cycle mem_req first rises.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, REQ, WAIT}
  - source enum {SRC_IF, SRC_DATA}
  - constant FETCH_SIZE = 3'b010
- Single module. The streak counter and FSM are inline; no sub-module is warranted.

## Test plan
- **Single fetch:** if_req, if_addr = 0x100, mem_ready in cycle 1, mem_rvalid in cycle 2 with rdata 0x00000013.
  - Cycle 1: mem_req = 1, mem_addr = 0x100, mem_size = 010, mem_we = 0.
  - Cycle 3: if_valid pulse, if_rdata = 0x13.
  - stall_if is high in cycles 0–2.
- **Simultaneous requests:** if_req (0x104) and d_read (0x2000, funct3 = 010).
  - Data is granted first; d_done carries d_rdata.
  - Fetch is granted the cycle after d_done; mem_addr = 0x104.
- **Store:** d_write, addr 0x3000, wdata 0xDEADBEEF, funct3 = 000.
  - mem_we = 1, mem_size = 000, mem_wdata = 0xDEADBEEF.
  - d_done pulses; d_rdata is unchanged from its prior value.
- **Starvation:** STARVE_MAX = 4, d_read is re-raised after every d_done, and if_req is held high.
  - Exactly 4 data grants occur, then a fetch grant; streak returns to 0.
- **Backpressure:** mem_ready held low for 5 cycles in REQ.
  - mem_req and all mem_* outputs stay stable.
  - stall_mem stays high until d_done.
- **Reset in WAIT:** assert rst, then drive mem_rvalid afterwards.
  - All outputs are 0 immediately; state = IDLE.
  - The late rvalid produces no done pulse.
